// File: rtl/keypad_scanner_pkg.sv
// Shared keypad definitions: FSM states, frame classes and the Pmod KYPD key map,
// so the display path and any later keypad consumer decode keys identically.
package keypad_scanner_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEBOUNCE,
      ST_PRESSED,
      ST_RELEASE
   } scanState_t;

   typedef enum logic [1:0] {
      FR_NONE,
      FR_SINGLE,
      FR_MULTI
   } frameClass_t;

   // Nibble (row*4 + col) holds the hex code printed on that key.
   localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

   function automatic logic [3:0] keyCode(input logic [1:0] rowIdx, input logic [1:0] colIdx);
      logic [5:0] base;
      base = {rowIdx, colIdx, 2'b00};
      return KEY_MAP[base +: 4];
   endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the four asynchronous, active-low keypad row lines.
module row_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] i_row,
   output logic [3:0] o_row
);

   logic [3:0] r_meta;
   logic [3:0] r_sync;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_meta <= 4'b1111;
         r_sync <= 4'b1111;
      end else begin
         r_meta <= i_row;
         r_sync <= r_meta;
      end
   end

   assign o_row = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, frame classification, debounce FSM
// and a four-deep digit history feeding the seven-segment driver.
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int SCAN_DIV        = 100000,
   parameter int DEBOUNCE_FRAMES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic [3:0]  key,
   output logic        key_valid,
   output logic        key_held,
   output logic [15:0] digits
);

   localparam int DWELL_W = $clog2(SCAN_DIV);
   localparam int CNT_W   = $clog2(DEBOUNCE_FRAMES + 1);

   logic [3:0]         w_row;
   logic [DWELL_W-1:0] r_dwell;
   logic [1:0]         r_colIdx;
   logic [3:0]         r_colSamp [4];
   logic               r_evalPending;
   logic               w_sampleNow;

   row_sync u_rowSync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_row (row),
      .o_row (w_row)
   );

   assign w_sampleNow = (r_dwell == DWELL_W'(SCAN_DIV - 1));

   // Samples are stored active-high (1 = key closed) per column; the frame is
   // complete after the column-3 sample and evaluated on the following cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_dwell       <= '0;
         r_colIdx      <= 2'd0;
         r_evalPending <= 1'b0;
         for (int c = 0; c < 4; c++) r_colSamp[c] <= 4'b0000;
      end else begin
         r_evalPending <= 1'b0;
         if (w_sampleNow) begin
            r_dwell              <= '0;
            r_colIdx             <= r_colIdx + 2'd1;
            r_colSamp[r_colIdx]  <= ~w_row;
            r_evalPending        <= (r_colIdx == 2'd3);
         end else begin
            r_dwell <= r_dwell + DWELL_W'(1);
         end
      end
   end

   assign col = ~(4'b0001 << r_colIdx);

   logic [4:0]  w_hits;
   logic [1:0]  w_hitRow;
   logic [1:0]  w_hitCol;
   frameClass_t w_frameClass;
   logic [3:0]  w_frameKey;

   always_comb begin
      w_hits   = 5'd0;
      w_hitRow = 2'd0;
      w_hitCol = 2'd0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (r_colSamp[c][r]) begin
               w_hits   = w_hits + 5'd1;
               w_hitRow = 2'(r);
               w_hitCol = 2'(c);
            end
         end
      end
      if (w_hits == 5'd0)      w_frameClass = FR_NONE;
      else if (w_hits == 5'd1) w_frameClass = FR_SINGLE;
      else                     w_frameClass = FR_MULTI;
      w_frameKey = keyCode(w_hitRow, w_hitCol);
   end

   scanState_t  r_state, w_stateNext;
   logic [CNT_W-1:0] r_cnt, w_cntNext, w_cntInc;
   logic [3:0]  r_cand, w_candNext;
   logic [3:0]  r_key, w_keyNext;
   logic        r_keyValid, w_keyValidNext;
   logic        r_keyHeld, w_keyHeldNext;
   logic [15:0] r_digits, w_digitsNext;
   logic        w_accept, w_release, w_single;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_cand     <= 4'h0;
         r_key      <= 4'h0;
         r_keyValid <= 1'b0;
         r_keyHeld  <= 1'b0;
         r_digits   <= 16'h0000;
      end else begin
         r_state    <= w_stateNext;
         r_cnt      <= w_cntNext;
         r_cand     <= w_candNext;
         r_key      <= w_keyNext;
         r_keyValid <= w_keyValidNext;
         r_keyHeld  <= w_keyHeldNext;
         r_digits   <= w_digitsNext;
      end
   end

   // The FSM only moves on evaluation cycles; accept/release are shared actions
   // reached either from the debounce states or directly when one frame suffices.
   always_comb begin
      w_stateNext    = r_state;
      w_cntNext      = r_cnt;
      w_candNext     = r_cand;
      w_keyNext      = r_key;
      w_keyValidNext = 1'b0;
      w_keyHeldNext  = r_keyHeld;
      w_digitsNext   = r_digits;
      w_accept       = 1'b0;
      w_release      = 1'b0;
      w_cntInc       = r_cnt + CNT_W'(1);
      w_single       = (w_frameClass == FR_SINGLE);

      if (r_evalPending) begin
         case (r_state)
            ST_IDLE: begin
               if (w_single) begin
                  w_candNext = w_frameKey;
                  w_cntNext  = CNT_W'(1);
                  if (DEBOUNCE_FRAMES == 1) w_accept    = 1'b1;
                  else                      w_stateNext = ST_DEBOUNCE;
               end
            end
            ST_DEBOUNCE: begin
               if (!w_single) begin
                  w_stateNext = ST_IDLE;
               end else if (w_frameKey == r_cand) begin
                  w_cntNext = w_cntInc;
                  if (w_cntInc == CNT_W'(DEBOUNCE_FRAMES)) w_accept = 1'b1;
               end else begin
                  w_candNext = w_frameKey;
                  w_cntNext  = CNT_W'(1);
               end
            end
            ST_PRESSED: begin
               if (w_frameClass == FR_NONE) begin
                  w_cntNext = CNT_W'(1);
                  if (DEBOUNCE_FRAMES == 1) w_release   = 1'b1;
                  else                      w_stateNext = ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (w_single && (w_frameKey == r_key)) begin
                  w_stateNext = ST_PRESSED;
               end else begin
                  w_cntNext = w_cntInc;
                  if (w_cntInc == CNT_W'(DEBOUNCE_FRAMES)) w_release = 1'b1;
               end
            end
            default: w_stateNext = ST_IDLE;
         endcase
      end

      if (w_accept) begin
         w_keyNext      = w_frameKey;
         w_keyValidNext = 1'b1;
         w_digitsNext   = {r_digits[11:0], w_frameKey};
         w_keyHeldNext  = 1'b1;
         w_stateNext    = ST_PRESSED;
      end
      if (w_release) begin
         w_keyHeldNext = 1'b0;
         w_stateNext   = ST_IDLE;
      end
   end

   assign key       = r_key;
   assign key_valid = r_keyValid;
   assign key_held  = r_keyHeld;
   assign digits    = r_digits;

endmodule
